// File: rtl/lfsr_msg_decrypt.sv
// Receive-side engine for the LFSR stream cipher with MSB parity: recovers the
// tap pattern and seed from the space preamble, then writes the stripped plaintext.
module lfsr_msg_decrypt #(
  parameter int BASE_IN  = 64,
  parameter int BASE_OUT = 0,
  parameter int MSG_LEN  = 64,
  parameter int PRE_MIN  = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic       Ack,
  output logic       no_match,
  output logic [3:0] ptrn_idx,
  output logic [6:0] par_errs
);

  typedef enum logic [2:0] {IDLE, SEED, TRY, DEC, WR, FILL, DONE} state_t;

  state_t     state;
  logic       start_q;
  logic [6:0] seed;
  logic [6:0] lfsr;
  logic [3:0] pat;
  logic [6:0] idx;
  logic [6:0] wptr;
  logic       in_pre;
  logic [6:0] plain_q;

  function automatic logic [6:0] tap_of(input logic [3:0] p);
    case (p)
      4'd0:    return 7'h60;
      4'd1:    return 7'h48;
      4'd2:    return 7'h78;
      4'd3:    return 7'h72;
      4'd4:    return 7'h6A;
      4'd5:    return 7'h69;
      4'd6:    return 7'h5C;
      4'd7:    return 7'h7E;
      default: return 7'h7B;
    endcase
  endfunction

  function automatic logic [6:0] step(input logic [6:0] s, input logic [6:0] t);
    return {s[5:0], ^(s & t)};
  endfunction

  logic [6:0] plain;
  logic       par_bad;
  logic       last_byte;
  logic       fill_due;

  assign plain     = mem_rdata[6:0] ^ lfsr;
  assign par_bad   = mem_rdata[7] != ^mem_rdata[6:0];
  assign last_byte = idx == 7'(MSG_LEN - 1);
  assign fill_due  = wptr < 7'(MSG_LEN);

  // Reads and writes share one port; the active state picks the address.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (state)
      SEED:     mem_addr = 8'(BASE_IN);
      TRY, DEC: mem_addr = 8'(BASE_IN) + {1'b0, idx};
      WR: begin
        mem_addr  = 8'(BASE_OUT) + {1'b0, wptr};
        mem_wdata = {1'b0, plain_q};
        mem_we    = 1'b1;
      end
      FILL: if (fill_due) begin
        mem_addr  = 8'(BASE_OUT) + {1'b0, wptr};
        mem_wdata = 8'h20;
        mem_we    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      seed     <= '0;
      lfsr     <= '0;
      pat      <= '0;
      idx      <= '0;
      wptr     <= '0;
      in_pre   <= 1'b0;
      plain_q  <= '0;
      Ack      <= 1'b0;
      no_match <= 1'b0;
      ptrn_idx <= '0;
      par_errs <= '0;
    end else begin
      start_q <= Start;
      case (state)
        IDLE: begin
          Ack      <= 1'b0;
          no_match <= 1'b0;
          par_errs <= '0;
          if (start_q && !Start) state <= SEED;
        end
        SEED: begin
          seed     <= mem_rdata[6:0] ^ 7'h20;
          lfsr     <= step(mem_rdata[6:0] ^ 7'h20, tap_of(4'd0));
          pat      <= '0;
          idx      <= 7'd1;
          wptr     <= '0;
          ptrn_idx <= '0;
          state    <= TRY;
        end
        // Candidate patterns are tried in index order, so the lowest fit wins.
        TRY: begin
          if (plain != 7'h20) begin
            if (pat < 4'd8) begin
              pat  <= pat + 4'd1;
              lfsr <= step(seed, tap_of(pat + 4'd1));
              idx  <= 7'd1;
            end else begin
              no_match <= 1'b1;
              Ack      <= 1'b1;
              state    <= DONE;
            end
          end else if (idx == 7'(PRE_MIN - 1)) begin
            ptrn_idx <= pat;
            lfsr     <= seed;
            idx      <= '0;
            in_pre   <= 1'b1;
            state    <= DEC;
          end else begin
            idx  <= idx + 7'd1;
            lfsr <= step(lfsr, tap_of(pat));
          end
        end
        DEC: begin
          lfsr <= step(lfsr, tap_of(pat));
          if (par_bad && par_errs != 7'h7F) par_errs <= par_errs + 7'd1;
          if (in_pre && plain == 7'h20) begin
            if (last_byte) state <= FILL;
            else           idx   <= idx + 7'd1;
          end else begin
            in_pre  <= 1'b0;
            plain_q <= plain;
            state   <= WR;
          end
        end
        WR: begin
          wptr <= wptr + 7'd1;
          if (last_byte) begin
            state <= FILL;
          end else begin
            idx   <= idx + 7'd1;
            state <= DEC;
          end
        end
        FILL: begin
          if (fill_due) begin
            wptr <= wptr + 7'd1;
          end else begin
            Ack   <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (Start) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_msg_decrypt.sv
// Scoreboard bench for lfsr_msg_decrypt: ciphertext is built by an encrypter
// model, expected writes/results are queued and a monitor checks them.
module tb_lfsr_msg_decrypt;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       Ack;
  logic       no_match;
  logic [3:0] ptrn_idx;
  logic [6:0] par_errs;

  typedef struct packed {logic [7:0] addr; logic [7:0] data;} wr_t;
  typedef struct packed {logic nm; logic [3:0] idx; logic [6:0] pe;} res_t;

  logic [7:0] dm [0:255];
  logic [7:0] plain_buf [0:63];
  wr_t        exp_wr[$];
  res_t       exp_res[$];
  int         tests = 0;
  int         fails = 0;
  string      msg = "Mr. Watson, come here. I want to see you.";

  logic       ack_prev;
  logic       pend;
  logic [7:0] pend_a;
  logic [7:0] pend_d;
  wr_t        w;
  res_t       r;

  assign mem_rdata = dm[mem_addr];

  initial forever #5 Clk = ~Clk;

  lfsr_msg_decrypt dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .Ack(Ack), .no_match(no_match), .ptrn_idx(ptrn_idx), .par_errs(par_errs)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] enc_step(input logic [6:0] s, input logic [6:0] t);
    return {s[5:0], ^(s & t)};
  endfunction

  task automatic build_plain(input int pre, input bit all_space);
    for (int i = 0; i < 64; i++) begin
      if (all_space || i < pre || i >= pre + msg.len()) plain_buf[i] = 8'h20;
      else plain_buf[i] = msg[i - pre];
    end
  endtask

  task automatic encrypt(input logic [6:0] taps, input logic [6:0] init);
    logic [6:0] s;
    logic [6:0] c;
    s = init;
    for (int i = 0; i < 64; i++) begin
      c = plain_buf[i][6:0] ^ s;
      dm[64 + i] = {^c, c};
      s = enc_step(s, taps);
    end
  endtask

  task automatic preload_out();
    for (int k = 0; k < 64; k++) dm[k] = 8'hA5;
  endtask

  // Plaintext with leading spaces stripped, padded with spaces to 64 bytes.
  function automatic logic [7:0] exp_out(input int k);
    int f;
    f = 64;
    for (int i = 63; i >= 0; i--) if (plain_buf[i] != 8'h20) f = i;
    if (f + k < 64) return plain_buf[f + k];
    return 8'h20;
  endfunction

  task automatic push_expect(input bit nm, input logic [3:0] idx, input logic [6:0] pe);
    res_t rr;
    wr_t  ww;
    rr.nm = nm; rr.idx = idx; rr.pe = pe;
    exp_res.push_back(rr);
    if (!nm) begin
      for (int k = 0; k < 64; k++) begin
        ww.addr = 8'(k);
        ww.data = exp_out(k);
        exp_wr.push_back(ww);
      end
    end
  endtask

  task automatic apply_stimulus();
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    @(negedge Clk);
  endtask

  task automatic wait_done(input string name);
    for (int c = 0; c < 3000 && !Ack; c++) @(negedge Clk);
    check_output({name, "_ack"}, Ack, 1);
    @(negedge Clk);
  endtask

  task automatic check_dm(input string name, input bit nm);
    int bad;
    bad = 0;
    for (int k = 0; k < 64; k++) if (dm[k] !== (nm ? 8'hA5 : exp_out(k))) bad++;
    check_output({name, "_dm_bad_bytes"}, bad, 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check_output({name, "_mem_addr"},  mem_addr, 0);
    check_output({name, "_mem_wdata"}, mem_wdata, 0);
    check_output({name, "_mem_we"},    mem_we, 0);
    check_output({name, "_ack"},       Ack, 0);
    check_output({name, "_no_match"},  no_match, 0);
    check_output({name, "_ptrn_idx"},  ptrn_idx, 0);
    check_output({name, "_par_errs"},  par_errs, 0);
  endtask

  task automatic run_case(input string name, input bit nm, input logic [3:0] idx, input logic [6:0] pe);
    preload_out();
    push_expect(nm, idx, pe);
    apply_stimulus();
    wait_done(name);
    check_output({name, "_writes_left"}, exp_wr.size(), 0);
    check_output({name, "_results_left"}, exp_res.size(), 0);
    check_dm(name, nm);
  endtask

  initial begin
    Reset    = 1'b0;
    Start    = 1'b0;
    ack_prev = 1'b0;
    pend     = 1'b0;
    pend_a   = '0;
    pend_d   = '0;
    for (int k = 0; k < 256; k++) dm[k] = 8'h00;

    // Monitor: compares every write and every completion against the queues,
    // then commits the write to the memory model on the following rising edge.
    fork
      forever begin
        @(negedge Clk);
        pend = 1'b0;
        if (Reset && mem_we) begin
          pend   = 1'b1;
          pend_a = mem_addr;
          pend_d = mem_wdata;
          check_output("write_expected", exp_wr.size() > 0, 1);
          if (exp_wr.size() > 0) begin
            w = exp_wr.pop_front();
            check_output("write_addr", mem_addr, w.addr);
            check_output("write_data", mem_wdata, w.data);
          end
        end
        if (Reset && Ack && !ack_prev) begin
          check_output("result_expected", exp_res.size() > 0, 1);
          if (exp_res.size() > 0) begin
            r = exp_res.pop_front();
            check_output("no_match", no_match, r.nm);
            if (!r.nm) begin
              check_output("ptrn_idx", ptrn_idx, r.idx);
              check_output("par_errs", par_errs, r.pe);
            end
          end
        end
        ack_prev = Ack;
        @(posedge Clk);
        if (pend && Reset) dm[pend_a] = pend_d;
      end
    join_none

    repeat (3) @(negedge Clk);
    check_reset_outputs("reset");
    Reset = 1'b1;

    build_plain(10, 1'b0);
    encrypt(7'h60, 7'h01);
    check_output("cipher_dm64", dm[64], 8'h21);
    check_output("cipher_dm65", dm[65], 8'h22);
    run_case("taps60", 1'b0, 4'd0, 7'd0);

    build_plain(26, 1'b0);
    encrypt(7'h7B, 7'h55);
    run_case("taps7b", 1'b0, 4'd8, 7'd0);

    build_plain(10, 1'b0);
    encrypt(7'h60, 7'h01);
    dm[70]  = dm[70]  ^ 8'h80;
    dm[100] = dm[100] ^ 8'h80;
    run_case("parity", 1'b0, 4'd0, 7'd2);

    build_plain(10, 1'b0);
    encrypt(7'h60, 7'h01);
    dm[66] = dm[66] ^ 8'h02;
    run_case("nomatch", 1'b1, 4'd0, 7'd0);

    // Abort in the middle of DEC, then rerun the same data from scratch.
    build_plain(10, 1'b0);
    encrypt(7'h60, 7'h01);
    preload_out();
    push_expect(1'b0, 4'd0, 7'd0);
    apply_stimulus();
    for (int c = 0; c < 2000 && mem_addr !== 8'd94; c++) @(negedge Clk);
    check_output("abort_reach_i30", mem_addr, 8'd94);
    Reset = 1'b0;
    #1;
    check_reset_outputs("abort");
    exp_wr.delete();
    exp_res.delete();
    @(negedge Clk);
    Reset = 1'b1;
    run_case("rerun", 1'b0, 4'd0, 7'd0);

    build_plain(10, 1'b1);
    encrypt(7'h60, 7'h01);
    run_case("allspace", 1'b0, 4'd0, 7'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lfsr_msg_decrypt.md
Name: lfsr_msg_decrypt

Overview:
- Hardware decryption engine for the LFSR stream cipher with MSB parity used by the encryption program. It is the receive-side counterpart of that encrypter.
- Reads 64 encrypted bytes from data memory DM[64..127] and recovers the tap pattern and start state from the known space preamble.
- Strips the preamble and writes the plaintext message to DM[0..63], space-padded at the end.
- Sits beside the program core on the shared data-memory port and uses the same Start/Ack program handshake.

Parameters:
- BASE_IN, 64, first address of the encrypted block.
- BASE_OUT, 0, first address of the plaintext block.
- MSG_LEN, 64, bytes processed per run.
- PRE_MIN, 10, guaranteed minimum preamble length; this is the number of bytes used for pattern search.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  program request; the run launches on a Start 1->0 transition.
- mem_addr  output  8  data-memory address.
- mem_rdata  input  8  data-memory read data; combinational, valid in the same cycle as mem_addr.
- mem_wdata  output  8  write data.
- mem_we  output  1  write enable; the write commits on the rising Clk.
- Ack  output  1  run complete.
- no_match  output  1  no tap pattern fit the preamble.
- ptrn_idx  output  4  recovered tap-pattern index, 0..8.
- par_errs  output  7  count of bytes with bad parity.

Behaviour:
- Reset (Reset=0, async): state IDLE. All outputs 0: mem_addr, mem_wdata, mem_we, Ack, no_match, ptrn_idx, par_errs. Internal counters and registers cleared.
- Reset mid-run aborts immediately. Any write not yet clocked is dropped.
- Tap table (fixed, 7-bit), index 0..8: 60,48,78,72,6A,69,5C,7E,7B hex.
- LFSR step: next = {s[5:0], ^(s & taps)}.
- Plain byte i: p = c[6:0] ^ s_i, with bit 7 forced to 0.
- Parity: a byte is bad when c[7] != ^c[6:0]. Each bad byte increments par_errs, saturating at 127. The byte is still decrypted.
- FSM:
  - IDLE: Start sampled 1 then 0 on consecutive edges -> SEED. Ack=0, no_match=0, par_errs=0.
  - SEED (1 cycle): mem_addr=BASE_IN. seed = mem_rdata[6:0] ^ 7'h20; p=0 -> TRY.
  - TRY: s starts at step(seed, taps[p]); i runs 1..PRE_MIN-1; mem_addr=BASE_IN+i; one compare per cycle.
    - If mem_rdata[6:0]^s != 7'h20: mismatch. If p<8, then p++ and restart at i=1; else no_match=1 -> DONE, with no memory writes.
    - All PRE_MIN-1 compares pass: ptrn_idx=p -> DEC.
    - Lowest matching p wins.
  - DEC: i=0..MSG_LEN-1, one byte per cycle, mem_addr=BASE_IN+i.
    - While still in preamble (no non-space seen yet) and p==0x20: skip, no write.
    - Otherwise: mem_we=1 for one cycle, write address BASE_OUT+wptr, wptr++. Write and read addresses are time-multiplexed: the read cycle is followed by a write cycle, so each kept byte costs 2 cycles and each skipped byte costs 1.
    - An all-space message writes nothing in DEC.
  - FILL: while wptr<MSG_LEN, write 0x20 at BASE_OUT+wptr (1 cycle each), then -> DONE.
  - DONE: Ack=1, held, along with ptrn_idx, no_match, par_errs. Start=1 -> IDLE, which clears Ack the next cycle.
- mem_we is 0 in every state except the DEC write cycle and FILL.
- The output range never exceeds BASE_OUT+MSG_LEN-1; wptr wraps are impossible because kept bytes are at most MSG_LEN.
- Start is ignored outside IDLE and DONE.

Test Plan:
- Taps 0x60, init 0x01, preamble 10, "Mr. Watson, come here. I want to see you." encrypted per the encrypt bench; DM[64]=0x21, DM[65]=0x22 -> ptrn_idx=0, DM[0..40] = message, DM[41..63]=0x20, par_errs=0, Ack=1.
- Same message with taps 0x7B (index 8), init 0x55, preamble 26 -> ptrn_idx=8, correct plaintext, no_match=0. Checks the full search cost: 8 early-mismatch patterns before the hit.
- Flip bit 7 of DM[70] and DM[100] -> par_errs=2, plaintext still correct.
- Corrupt DM[66] so no pattern fits -> no_match=1, Ack=1, no writes (DM[0..63] unchanged).
- Assert Reset=0 during DEC at i=30 -> outputs 0 immediately; a new Start pulse runs to a correct result.
- All-space message (64 spaces) -> zero DEC writes, FILL writes DM[0..63]=0x20, Ack=1.
